autocorr_accumulator: RTL and testbench

//  Downstream stage of the 5-lag autocorrelator. Integrates the per-lag 2-bit outputs
//  (lag0..lag4) over ACC_FRAMES valid frames, then scans the sums for the peak lag.

---
 rtl/autocorr_pkg.sv | 23 ++
 rtl/autocorr_accumulator.sv | 118 +++++++++++
 tb/tb_autocorr_accumulator.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/autocorr_pkg.sv
// Shared constants, accumulator width helper and FSM state type for the
// autocorrelator accumulation stage.
package autocorr_pkg;

  localparam int unsigned LAG_W    = 2;
  localparam int unsigned NUM_LAGS = 5;
  localparam int unsigned ZERO_LAG = 2;
  localparam int unsigned IDX_W    = 3;

  // Sum width that cannot overflow for the given number of frames, never below LAG_W+1.
  function automatic int unsigned acc_width(input int unsigned frames);
    int unsigned w;
    w = LAG_W + $clog2(frames);
    return (w < LAG_W + 1) ? LAG_W + 1 : w;
  endfunction

  typedef enum logic [1:0] {
    ACCUM,
    SEARCH,
    HOLD
  } acc_state_t;

endpackage

// File: rtl/autocorr_accumulator.sv
// Integrates the five per-lag products over ACC_FRAMES frames, scans the sums for the
// peak lag one entry per cycle and holds the result on a valid/ready port.
module autocorr_accumulator
  import autocorr_pkg::*;
#(
  parameter int unsigned ACC_FRAMES = 8,
  parameter bit          SKIP_ZERO  = 1'b1,
  localparam int unsigned ACC_W     = acc_width(ACC_FRAMES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LAG_W-1:0] lag0,
  input  logic [LAG_W-1:0] lag1,
  input  logic [LAG_W-1:0] lag2,
  input  logic [LAG_W-1:0] lag3,
  input  logic [LAG_W-1:0] lag4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc0,
  output logic [ACC_W-1:0] acc1,
  output logic [ACC_W-1:0] acc2,
  output logic [ACC_W-1:0] acc3,
  output logic [ACC_W-1:0] acc4,
  output logic [2:0]       peak_lag,
  output logic [ACC_W-1:0] peak_val,
  output logic             overrun
);

  localparam int unsigned CNT_W = (ACC_FRAMES > 1) ? $clog2(ACC_FRAMES) : 1;

  acc_state_t       state_q;
  logic [ACC_W-1:0] acc_q [NUM_LAGS];
  logic [LAG_W-1:0] lag_in [NUM_LAGS];
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [ACC_W-1:0] peak_val_q;
  logic [IDX_W-1:0] peak_lag_q;
  logic             out_valid_q;
  logic             overrun_q;
  logic             scan_skip;
  logic             scan_win;

  assign lag_in[0] = lag0;
  assign lag_in[1] = lag1;
  assign lag_in[2] = lag2;
  assign lag_in[3] = lag3;
  assign lag_in[4] = lag4;

  // Decide whether the lag under the scan index becomes the new peak (strict, lowest wins).
  always_comb begin
    scan_skip = SKIP_ZERO && (idx_q == IDX_W'(ZERO_LAG));
    scan_win  = !scan_skip && (acc_q[idx_q] > peak_val_q);
  end

  // Accumulate / scan / hold state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      idx_q       <= '0;
      peak_val_q  <= '0;
      peak_lag_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_LAGS; i++) acc_q[i] <= '0;
    end else begin
      if (in_valid && !in_ready) overrun_q <= 1'b1;
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_LAGS; i++) acc_q[i] <= acc_q[i] + ACC_W'(lag_in[i]);
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ACC_FRAMES - 1)) begin
              state_q    <= SEARCH;
              idx_q      <= '0;
              peak_val_q <= '0;
              peak_lag_q <= '0;
            end
          end
        end
        SEARCH: begin
          if (scan_win) begin
            peak_val_q <= acc_q[idx_q];
            peak_lag_q <= idx_q;
          end
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_LAGS - 1)) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ACCUM;
            for (int i = 0; i < NUM_LAGS; i++) acc_q[i] <= '0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign peak_lag  = peak_lag_q;
  assign peak_val  = peak_val_q;
  assign acc0      = acc_q[0];
  assign acc1      = acc_q[1];
  assign acc2      = acc_q[2];
  assign acc3      = acc_q[3];
  assign acc4      = acc_q[4];

endmodule

// File: tb/tb_autocorr_accumulator.sv
// Bench for autocorr_accumulator: two instances (peak scan skipping / including the
// zero lag) share one stimulus; a frame-level model is compared every cycle.
module tb_autocorr_accumulator;
  import autocorr_pkg::*;

  localparam int unsigned FRAMES = 8;
  localparam int unsigned AW     = acc_width(FRAMES);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [1:0]    lag [5];
  logic          in_ready_s, in_ready_a, out_valid_s, out_valid_a, overrun_s, overrun_a;
  logic [AW-1:0] acc_s [5];
  logic [AW-1:0] acc_a [5];
  logic [2:0]    peak_lag_s, peak_lag_a;
  logic [AW-1:0] peak_val_s, peak_val_a;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  autocorr_accumulator #(.ACC_FRAMES(FRAMES), .SKIP_ZERO(1'b1)) u_skip (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .lag0(lag[0]), .lag1(lag[1]), .lag2(lag[2]), .lag3(lag[3]), .lag4(lag[4]),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .acc0(acc_s[0]), .acc1(acc_s[1]), .acc2(acc_s[2]), .acc3(acc_s[3]), .acc4(acc_s[4]),
    .peak_lag(peak_lag_s), .peak_val(peak_val_s), .overrun(overrun_s)
  );

  autocorr_accumulator #(.ACC_FRAMES(FRAMES), .SKIP_ZERO(1'b0)) u_all (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .lag0(lag[0]), .lag1(lag[1]), .lag2(lag[2]), .lag3(lag[3]), .lag4(lag[4]),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .acc0(acc_a[0]), .acc1(acc_a[1]), .acc2(acc_a[2]), .acc3(acc_a[3]), .acc4(acc_a[4]),
    .peak_lag(peak_lag_a), .peak_val(peak_val_a), .overrun(overrun_a)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Peak over plain sums: strictly larger wins, lowest index on ties, optional zero-lag skip.
  function automatic int peak_of(input int s [5], input bit skip, input bit want_idx);
    int best_v;
    int best_i;
    best_v = 0;
    best_i = 0;
    for (int i = 0; i < 5; i++) begin
      if (!(skip && i == ZERO_LAG) && s[i] > best_v) begin
        best_v = s[i];
        best_i = i;
      end
    end
    return want_idx ? best_i : best_v;
  endfunction

  // Frame-level model: mode 0 collecting, 1 waiting for the scan, 2 result held.
  int m_mode;
  int m_cnt;
  int m_wait;
  int m_ovr;
  int m_acc [5];
  int m_pl_s, m_pv_s, m_pl_a, m_pv_a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0;
      m_cnt  <= 0;
      m_wait <= 0;
      m_ovr  <= 0;
      for (int i = 0; i < 5; i++) m_acc[i] <= 0;
    end else begin
      if (in_valid && m_mode != 0) m_ovr <= 1;
      case (m_mode)
        0: if (in_valid) begin
          for (int i = 0; i < 5; i++) m_acc[i] <= m_acc[i] + int'(lag[i]);
          m_cnt <= m_cnt + 1;
          if (m_cnt == FRAMES - 1) begin
            m_mode <= 1;
            m_wait <= NUM_LAGS;
          end
        end
        1: begin
          m_wait <= m_wait - 1;
          if (m_wait == 1) begin
            m_mode <= 2;
            m_pl_s <= peak_of(m_acc, 1'b1, 1'b1);
            m_pv_s <= peak_of(m_acc, 1'b1, 1'b0);
            m_pl_a <= peak_of(m_acc, 1'b0, 1'b1);
            m_pv_a <= peak_of(m_acc, 1'b0, 1'b0);
          end
        end
        default: if (out_ready) begin
          m_mode <= 0;
          m_cnt  <= 0;
          for (int i = 0; i < 5; i++) m_acc[i] <= 0;
        end
      endcase
    end
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    check("in_ready_s", int'(in_ready_s), int'(m_mode == 0));
    check("in_ready_a", int'(in_ready_a), int'(m_mode == 0));
    check("out_valid_s", int'(out_valid_s), int'(m_mode == 2));
    check("out_valid_a", int'(out_valid_a), int'(m_mode == 2));
    check("overrun_s", int'(overrun_s), m_ovr);
    check("overrun_a", int'(overrun_a), m_ovr);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("acc_s[%0d]", i), int'(acc_s[i]), m_acc[i]);
      check($sformatf("acc_a[%0d]", i), int'(acc_a[i]), m_acc[i]);
    end
    if (m_mode == 2) begin
      check("peak_lag_s", int'(peak_lag_s), m_pl_s);
      check("peak_val_s", int'(peak_val_s), m_pv_s);
      check("peak_lag_a", int'(peak_lag_a), m_pl_a);
      check("peak_val_a", int'(peak_val_a), m_pv_a);
    end
  end

  // n frames; rot gives frame f lag i = (f+i)%4, gap spaces frames every third cycle.
  task automatic send(input int n, input int l0, input int l1, input int l2, input int l3,
                      input int l4, input bit gap, input bit rot);
    for (int f = 0; f < n; f++) begin
      @(negedge clk);
      lag[0] = rot ? 2'((f + 0) % 4) : 2'(l0);
      lag[1] = rot ? 2'((f + 1) % 4) : 2'(l1);
      lag[2] = rot ? 2'((f + 2) % 4) : 2'(l2);
      lag[3] = rot ? 2'((f + 3) % 4) : 2'(l3);
      lag[4] = rot ? 2'((f + 4) % 4) : 2'(l4);
      in_valid = 1'b1;
      if (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid_s) break;
    end
    check("out_valid_seen", int'(out_valid_s), 1);
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("acc1_cleared", int'(acc_s[1]), 0);
    check("in_ready_back", int'(in_ready_s), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 5; i++) lag[i] = 2'd0;
    #1;
    check("rst_acc2", int'(acc_s[2]), 0);
    check("rst_out_valid", int'(out_valid_s), 0);
    check("rst_peak_val", int'(peak_val_s), 0);
    check("rst_overrun", int'(overrun_s), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", int'(in_ready_s), 1);

    // Basic block; both scan modes and result latency.
    send(8, 0, 1, 3, 1, 0, 1'b0, 1'b0);
    wait_valid(lat);
    check("latency", lat, 5);
    check("t1_acc1", int'(acc_s[1]), 8);
    check("t1_acc2", int'(acc_s[2]), 24);
    check("t1_acc4", int'(acc_s[4]), 0);
    check("t1_peak_lag_skip", int'(peak_lag_s), 1);
    check("t1_peak_val_skip", int'(peak_val_s), 8);
    check("t2_peak_lag_all", int'(peak_lag_a), 2);
    check("t2_peak_val_all", int'(peak_val_a), 24);
    consume();

    // Ties resolve to the lowest index.
    send(8, 2, 2, 1, 2, 2, 1'b0, 1'b0);
    wait_valid(lat);
    check("t3_acc0", int'(acc_s[0]), 16);
    check("t3_acc2", int'(acc_s[2]), 8);
    check("t3_peak_lag_skip", int'(peak_lag_s), 0);
    check("t3_peak_val_skip", int'(peak_val_s), 16);
    check("t3_peak_lag_all", int'(peak_lag_a), 0);
    consume();

    // Back-pressure with frames arriving: result stable, frames dropped, overrun sticks.
    send(8, 1, 1, 2, 3, 0, 1'b0, 1'b0);
    wait_valid(lat);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) lag[i] = 2'd3;
      in_valid = 1'b1;
      #1;
      check("t4_in_ready", int'(in_ready_s), 0);
      check("t4_acc3_stable", int'(acc_s[3]), 24);
      check("t4_peak_lag", int'(peak_lag_s), 3);
    end
    check("t4_overrun", int'(overrun_s), 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("t4_acc3_cleared", int'(acc_s[3]), 0);
    check("t4_in_ready_back", int'(in_ready_s), 1);
    do_reset();
    check("t4_overrun_reset", int'(overrun_s), 0);

    // Gapped frames.
    send(8, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    wait_valid(lat);
    check("t5_acc0", int'(acc_s[0]), 12);
    check("t5_acc4", int'(acc_s[4]), 12);
    check("t5_peak_lag", int'(peak_lag_s), 0);
    check("t5_peak_val", int'(peak_val_s), 12);
    consume();

    // Reset mid-block discards the partial sums and frame count.
    send(4, 1, 1, 1, 1, 1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_acc0_async", int'(acc_s[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8, 1, 0, 0, 0, 3, 1'b0, 1'b0);
    wait_valid(lat);
    check("t6_acc0", int'(acc_s[0]), 8);
    check("t6_acc4", int'(acc_s[4]), 24);
    check("t6_peak_lag", int'(peak_lag_s), 4);
    consume();

    // Reset during the scan.
    send(8, 3, 3, 3, 3, 3, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6s_acc2", int'(acc_s[2]), 0);
    check("t6s_out_valid", int'(out_valid_s), 0);
    check("t6s_in_ready", int'(in_ready_s), 1);
    @(negedge clk);
    rst_n = 1'b1;
    send(8, 0, 0, 0, 2, 0, 1'b0, 1'b0);
    wait_valid(lat);
    check("t6s_acc3", int'(acc_s[3]), 16);
    check("t6s_peak_lag", int'(peak_lag_s), 3);
    check("t6s_peak_val", int'(peak_val_s), 16);
    consume();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
